// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the
// parameterised serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FILLING = 2'b01,
    ARMED   = 2'b10
  } det_state_e;

  localparam logic [7:0] DEF_PAT = 8'b0001_1011;
  localparam int         DEF_LEN = 5;
  localparam bit         DEF_OVL = 1'b1;

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial data, configuration and result bundle
// of the sequence detector.
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             In;
  logic             in_valid;
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             clr_cnt;
  logic             Out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output In, in_valid, load,
    output pattern, pat_len, overlap,
    output clr_cnt,
    input  Out, match_count
  );

  modport slave (
    input  In, in_valid, load,
    input  pattern, pat_len, overlap,
    input  clr_cnt,
    output Out, match_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear strobe
// that overrides a coincident increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != MAX) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable
// pattern/length/overlap and a saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
  parameter int               DEF_LEN = seq_det_pkg::DEF_LEN,
  parameter bit               DEF_OVL = seq_det_pkg::DEF_OVL
) (
  input logic                  clk,
  input logic                  reset,
  seq_detector_param_if.slave  bus
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  det_state_e       state;
  det_state_e       state_n;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] hist_sh;
  logic [PAT_W-1:0] cfg_pat;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_n;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] cfg_len;
  logic [LEN_W-1:0] len_in;
  logic [CNT_W-1:0] cnt;
  logic             cfg_ovl;
  logic             out_q;
  logic             acc;
  logic             hit;

  assign acc      = bus.in_valid & ~bus.load;
  assign hist_sh  = {hist[PAT_W-2:0], bus.In};
  assign fill_inc = (fill == LEN_MAX) ? fill
                                      : fill + LEN_W'(1);
  assign len_mask = ~({PAT_W{1'b1}} << cfg_len);

  // Compare only the active low cfg_len bits after the shift.
  assign hit = acc
            && (((hist_sh ^ cfg_pat) & len_mask) == '0)
            && (fill_inc >= cfg_len);

  assign len_in = (bus.pat_len == '0 || bus.pat_len > LEN_MAX)
                ? LEN_MAX : bus.pat_len;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      hist    <= '0;
      fill    <= '0;
      out_q   <= 1'b0;
      cfg_pat <= DEF_PAT;
      cfg_len <= LEN_W'(DEF_LEN);
      cfg_ovl <= DEF_OVL;
    end else begin
      state <= state_n;
      hist  <= hist_n;
      fill  <= fill_n;
      out_q <= hit;
      if (bus.load) begin
        cfg_pat <= bus.pattern;
        cfg_len <= len_in;
        cfg_ovl <= bus.overlap;
      end
    end
  end

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    unique case (1'b1)
      bus.load: begin
        state_n = IDLE;
        hist_n  = '0;
        fill_n  = '0;
      end
      acc: begin
        if (hit && !cfg_ovl) begin
          state_n = IDLE;
          hist_n  = '0;
          fill_n  = '0;
        end else begin
          hist_n  = hist_sh;
          fill_n  = fill_inc;
          state_n = (fill_inc >= cfg_len) ? ARMED
                                          : FILLING;
        end
      end
      default: ;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (hit),
    .clr  (bus.clr_cnt),
    .count(cnt)
  );

  assign bus.Out         = out_q;
  assign bus.match_count = cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param
// plus a narrow-counter saturation sequence.
module tb_seq_detector_param;

  logic clk;
  logic rst_n;

  seq_detector_param_if #(.PAT_W(8), .CNT_W(8)) a ();
  seq_detector_param_if #(.PAT_W(8), .CNT_W(2)) b ();

  seq_detector_param #(.PAT_W(8), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (a)
  );

  seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk  (clk),
    .reset(rst_n),
    .bus  (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       v;
    logic       b;
    logic       clr;
    logic       eo;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    logic rst, logic ld, logic [7:0] pat,
    logic [3:0] len, logic ovl, logic v,
    logic bb, logic clr, logic eo, logic [7:0] ec
  );
    vec_t t;
    t.rst = rst; t.ld = ld; t.pat = pat;
    t.len = len; t.ovl = ovl; t.v = v;
    t.b = bb; t.clr = clr; t.eo = eo; t.ec = ec;
    return t;
  endfunction

  // Idle config fields hold junk that must not be captured.
  function automatic vec_t bt(logic bb, logic eo, logic [7:0] ec);
    return mk(1, 0, 8'h55, 4'd3, 0, 1, bb, 0, eo, ec);
  endfunction

  function automatic vec_t bub(logic [7:0] ec);
    return mk(1, 0, 8'h55, 4'd3, 0, 0, 0, 0, 0, ec);
  endfunction

  function automatic vec_t rs(logic bb);
    return mk(0, 1, 8'hFF, 4'd2, 0, 1, bb, 1, 0, 0);
  endfunction

  function automatic vec_t ld(
    logic [7:0] pat, logic [3:0] len, logic ovl,
    logic bb, logic [7:0] ec
  );
    return mk(1, 1, pat, len, ovl, 1, bb, 0, 0, ec);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    rst_n      = t.rst;
    a.load     = t.ld;
    a.pattern  = t.pat;
    a.pat_len  = t.len;
    a.overlap  = t.ovl;
    a.in_valid = t.v;
    a.In       = t.b;
    a.clr_cnt  = t.clr;
    @(posedge clk);
    #1;
    chk("out", idx, 32'(a.Out), 32'(t.eo));
    chk("count", idx, 32'(a.match_count), 32'(t.ec));
  endtask

  initial begin
    vec_t t;
    int   exp_c;
    rst_n = 1'b0;
    a.load = 0; a.pattern = 0; a.pat_len = 0; a.overlap = 0;
    a.in_valid = 0; a.In = 0; a.clr_cnt = 0;
    b.load = 0; b.pattern = 0; b.pat_len = 0; b.overlap = 0;
    b.in_valid = 0; b.In = 0; b.clr_cnt = 0;

    // Defaults, overlapping: 1,1,0,1,1,0,1,1
    tbl.push_back(rs(0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(0, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 1, 1));
    tbl.push_back(bt(0, 0, 1));
    tbl.push_back(bt(1, 0, 1));
    tbl.push_back(bt(1, 1, 2));
    // Non-overlapping 11011, same stream
    tbl.push_back(ld(8'h1B, 4'd5, 0, 0, 2));
    t = bub(0); t.clr = 1; tbl.push_back(t);
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(0, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 1, 1));
    tbl.push_back(bt(0, 0, 1));
    tbl.push_back(bt(1, 0, 1));
    tbl.push_back(bt(1, 0, 1));
    // Reset mid-pattern discards progress
    tbl.push_back(rs(0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(0, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(rs(1));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(0, 0, 0));
    tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 1, 1));
    // Load with coincident valid bit, 8-bit 10101010
    tbl.push_back(ld(8'hAA, 4'd8, 1, 1, 1));
    tbl.push_back(bt(1, 0, 1));
    tbl.push_back(bt(0, 0, 1));
    tbl.push_back(bt(1, 0, 1));
    tbl.push_back(bt(0, 0, 1));
    tbl.push_back(bt(1, 0, 1));
    tbl.push_back(bt(0, 0, 1));
    tbl.push_back(bt(1, 0, 1));
    tbl.push_back(bt(0, 1, 2));
    tbl.push_back(bt(1, 0, 2));
    tbl.push_back(bt(0, 1, 3));
    // pat_len 0 becomes 8: all-zero pattern
    tbl.push_back(ld(8'h00, 4'd0, 0, 0, 3));
    for (int i = 0; i < 7; i++) tbl.push_back(bt(0, 0, 3));
    tbl.push_back(bt(0, 1, 4));
    // Bubbles inside pattern, clear coincident with match
    tbl.push_back(ld(8'h1B, 4'd5, 1, 0, 4));
    tbl.push_back(bt(1, 0, 4));
    tbl.push_back(bub(4));
    tbl.push_back(bt(1, 0, 4));
    tbl.push_back(bt(0, 0, 4));
    tbl.push_back(bub(4));
    tbl.push_back(bub(4));
    tbl.push_back(bt(1, 0, 4));
    t = bt(1, 1, 0); t.clr = 1; tbl.push_back(t);
    tbl.push_back(bub(0));
    // pat_len above PAT_W becomes 8
    tbl.push_back(ld(8'hFF, 4'd15, 0, 0, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(bt(1, 0, 0));
    tbl.push_back(bt(1, 1, 1));
    tbl.push_back(bt(1, 0, 1));

    foreach (tbl[i]) apply(tbl[i], i);
    a.in_valid = 0; a.load = 0; a.clr_cnt = 0;
    rst_n = 1'b1;

    // 2-bit counter saturates: pattern 11, non-overlap
    b.load = 1; b.pattern = 8'h03;
    b.pat_len = 4'd2; b.overlap = 0;
    @(posedge clk);
    #1;
    chk("cnt2_load", 0, 32'(b.match_count), 0);
    b.load = 0;
    exp_c = 0;
    for (int i = 0; i < 10; i++) begin
      b.in_valid = 1; b.In = 1;
      @(posedge clk);
      #1;
      if (i % 2 == 1 && exp_c < 3) exp_c++;
      chk("out2", i, 32'(b.Out), 32'(i % 2 == 1));
      chk("cnt2", i, 32'(b.match_count), 32'(exp_c));
    end
    b.in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 8, SHALL set maximum pattern length in bits (legal 2..16).
REQ-002 Parameter CNT_W, default 8, SHALL set match counter width.
REQ-003 Parameter DEF_PAT, default 8'b0001_1011, SHALL be the pattern register reset value.
REQ-004 Parameter DEF_LEN, default 5, SHALL be the pattern-length reset value.
REQ-005 Parameter DEF_OVL, default 1, SHALL be the overlap-mode reset value.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 In  in  1  serial data bit, sampled only when in_valid=1.
REQ-009 in_valid  in  1  qualifies In for one cycle.
REQ-010 load  in  1  one-cycle strobe capturing pattern, pat_len and overlap.
REQ-011 pattern  in  PAT_W  target sequence; bit pat_len-1 is the first bit received, bit 0 the last.
REQ-012 pat_len  in  clog2(PAT_W+1)  active pattern length.
REQ-013 overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-014 clr_cnt  in  1  one-cycle strobe zeroing match_count.
REQ-015 Out  out  1  registered one-cycle match pulse.
REQ-016 match_count  out  CNT_W  saturating count of matches.

Function
REQ-017 A shift history SHALL take the new bit at LSB on each accepted bit (in_valid=1, load=0); history unchanged otherwise.
REQ-018 A fill counter SHALL increment per accepted bit, saturating at PAT_W.
REQ-019 A match SHALL occur when, after the shift, the history's low cfg_len bits equal cfg_pat[cfg_len-1:0] and the post-increment fill count >= cfg_len.
REQ-020 Out SHALL be 1 exactly in the cycle after the clock edge that accepted the completing bit (latency 1), and 0 in all other cycles.
REQ-021 Overlap mode: fill SHALL NOT be altered by a match; a suffix of one match SHALL be usable as a prefix of the next.
REQ-022 Non-overlap mode: on a match, fill SHALL be set to 0 and history cleared, so no bit contributes to two matches.
REQ-023 Controller states: IDLE (fill=0), FILLING (0<fill<cfg_len), ARMED (fill>=cfg_len); IDLE->FILLING on accepted bit; FILLING->ARMED when fill reaches cfg_len; ARMED->IDLE on non-overlap match; any state->IDLE on load.
REQ-024 load SHALL capture pattern/pat_len/overlap into cfg_pat/cfg_len/cfg_ovl and clear history and fill; Out SHALL be 0 next cycle.
REQ-025 load and in_valid in the same cycle: load SHALL win and the bit SHALL be discarded.
REQ-026 pat_len of 0 or >PAT_W at load SHALL be stored as PAT_W.
REQ-027 match_count SHALL increment by 1 per match, saturating at 2^CNT_W-1 (no wrap).
REQ-028 clr_cnt coincident with a match: match_count SHALL become 0 (clear wins).
REQ-029 load SHALL NOT alter match_count.
REQ-030 No input other than clk, reset SHALL affect state without the stated strobes.

Reset
REQ-031 While reset=0 at a rising edge: Out=0, match_count=0, history=0, fill=0, state IDLE, cfg_pat=DEF_PAT, cfg_len=DEF_LEN, cfg_ovl=DEF_OVL.
REQ-032 Reset asserted mid-pattern SHALL discard partial progress; first match after release requires cfg_len fresh bits.
REQ-033 Reset SHALL take priority over load, in_valid and clr_cnt.

Structure
REQ-034 Package seq_det_pkg SHALL hold state encodings (IDLE=2'b00, FILLING=2'b01, ARMED=2'b10) and DEF_PAT/DEF_LEN/DEF_OVL defaults.
REQ-035 One sub-module sat_counter (parameter W; inc, clr, synchronous active-low reset) SHALL implement match_count; history/compare stays in the top.

Verification
REQ-036 Defaults, bits 1,1,0,1,1,0,1,1 on consecutive valid cycles -> Out pulses after bits 5 and 8; match_count=2.
REQ-037 load overlap=0 (pattern 11011, len 5), same stream -> single pulse after bit 5; match_count=1.
REQ-038 Defaults, bits 1,1,0,1 then reset low 1 cycle then 1 -> no pulse; match_count=0.
REQ-039 CNT_W=2, 5 non-overlapping matches -> match_count sequence 1,2,3,3,3.
REQ-040 load pattern 8'b1010_1010 len 8 with in_valid=1 same cycle, then bits 10101010 -> pulse only after 8th post-load bit; pat_len=0 load -> cfg_len=8.
REQ-041 clr_cnt coincident with match -> Out=1, match_count=0 next cycle; bubbles (in_valid=0) inside a pattern -> match still detected, latency counted from completing bit.
